// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution datapath and its result streamer.
package conv_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } stream_state_e;

  // $clog2 that never returns a zero width, so single-entry dimensions still get a 1-bit signal.
  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

  // Flat element index for (channel, row, column). The convolution top level packs with the
  // same function, so both sides agree on ordering.
  function automatic int unsigned elem_index(input int unsigned c, input int unsigned r,
                                             input int unsigned k, input int unsigned rows,
                                             input int unsigned cols);
    return c * rows * cols + r * cols + k;
  endfunction

endpackage

// File: rtl/conv_stream_idx_ctr.sv
// Wrapping channel/row/column counter. Column wraps into row, row wraps into channel.
module conv_stream_idx_ctr
  import conv_pkg::*;
#(
  parameter int unsigned channels = 1,
  parameter int unsigned rows     = 2,
  parameter int unsigned cols     = 2,
  localparam int unsigned CW = clog2_min1(channels),
  localparam int unsigned RW = clog2_min1(rows),
  localparam int unsigned KW = clog2_min1(cols)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] ch,
  output logic [RW-1:0] row,
  output logic [KW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] ChMax  = CW'(channels - 1);
  localparam logic [RW-1:0] RowMax = RW'(rows - 1);
  localparam logic [KW-1:0] ColMax = KW'(cols - 1);

  logic [CW-1:0] ch_q;
  logic [RW-1:0] row_q;
  logic [KW-1:0] col_q;

  // Advance the triple; clear wins over increment so a capture on the last beat restarts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (clr) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      if (col_q == ColMax) begin
        col_q <= '0;
        if (row_q == RowMax) begin
          row_q <= '0;
          ch_q  <= (ch_q == ChMax) ? '0 : ch_q + CW'(1);
        end else begin
          row_q <= row_q + RW'(1);
        end
      end else begin
        col_q <= col_q + KW'(1);
      end
    end
  end

  // Position outputs and the final-element flag.
  always_comb begin
    ch   = ch_q;
    row  = row_q;
    col  = col_q;
    last = (ch_q == ChMax) && (row_q == RowMax) && (col_q == ColMax);
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures a full convolution result frame and replays it one element per beat over
// valid/ready with channel/row/column tags and a last flag.
// Build option: CONV_STREAM_RELU_EN zeroes elements whose sign bit is set on the output path.
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int unsigned data_width     = 16,
  parameter int unsigned output_channel = 1,
  parameter int unsigned result_width   = 2,
  parameter int unsigned result_length  = 2,
  localparam int unsigned N  = output_channel * result_width * result_length,
  localparam int unsigned IW = clog2_min1(N),
  localparam int unsigned CW = clog2_min1(output_channel),
  localparam int unsigned RW = clog2_min1(result_width),
  localparam int unsigned KW = clog2_min1(result_length)
) (
  input  logic                    clk,
  input  logic                    reset,
  // Element 0 sits at the MSB end of the frame.
  input  logic [N*data_width-1:0] result_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [data_width-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [CW-1:0]           m_ch,
  output logic [RW-1:0]           m_row,
  output logic [KW-1:0]           m_col,
  output logic                    overrun
);

  stream_state_e           state_q;
  logic                    m_valid_q;
  logic                    overrun_q;
  logic [N*data_width-1:0] buf_q;

  logic [CW-1:0]         ctr_ch;
  logic [RW-1:0]         ctr_row;
  logic [KW-1:0]         ctr_col;
  logic                  ctr_last;
  logic [IW-1:0]         idx;
  logic                  beat_fire;
  logic                  capture;
  logic [data_width-1:0] elem;

  conv_stream_idx_ctr #(
    .channels (output_channel),
    .rows     (result_width),
    .cols     (result_length)
  ) u_idx_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (beat_fire),
    .clr   (capture),
    .ch    (ctr_ch),
    .row   (ctr_row),
    .col   (ctr_col),
    .last  (ctr_last)
  );

  // Handshake decode, frame-accept window and element select from the registered buffer.
  always_comb begin
    beat_fire = m_valid_q & m_ready;
    in_ready  = (state_q == ST_IDLE) | (beat_fire & ctr_last);
    capture   = in_valid & in_ready;
    idx       = IW'(elem_index(int'(ctr_ch), int'(ctr_row), int'(ctr_col),
                               result_width, result_length));
    elem      = buf_q[(N - 1 - int'(idx)) * data_width +: data_width];
  end

  // Stream FSM: capture in IDLE, replay in STREAM, chain a new frame on the last handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            buf_q     <= result_in;
            state_q   <= ST_STREAM;
            m_valid_q <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (beat_fire && ctr_last) begin
            if (in_valid) begin
              buf_q <= result_in;
            end else begin
              state_q   <= ST_IDLE;
              m_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output path; data is forced to zero while no beat is offered.
  always_comb begin
    m_valid = m_valid_q;
    m_last  = m_valid_q & ctr_last;
    m_ch    = ctr_ch;
    m_row   = ctr_row;
    m_col   = ctr_col;
    overrun = overrun_q;
`ifdef CONV_STREAM_RELU_EN
    m_data  = (m_valid_q && !elem[data_width-1]) ? elem : '0;
`else
    m_data  = m_valid_q ? elem : '0;
`endif
  end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer with a 1x2x2 frame of 16-bit elements.
module tb_conv_result_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] result_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [0:0]  m_ch;
  logic [0:0]  m_row;
  logic [0:0]  m_col;
  logic        overrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  conv_result_streamer #(
    .data_width     (16),
    .output_channel (1),
    .result_width   (2),
    .result_length  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .result_in (result_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .m_ch      (m_ch),
    .m_row     (m_row),
    .m_col     (m_col),
    .overrun   (overrun)
  );

  localparam logic [63:0] FrameA = {16'h3C00, 16'hBC00, 16'h4000, 16'h0000};
  localparam logic [63:0] FrameB = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
  localparam logic [63:0] FrameR = {16'hBC00, 16'h3C00, 16'h8000, 16'h4000};

  typedef struct {
    logic        start;
    logic [63:0] frame;
    logic        rdy;
    logic        vld;
    logic [15:0] data;
    logic        last;
    logic        row;
    logic        col;
    logic        irdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] relu_ref(input logic [15:0] x);
`ifdef CONV_STREAM_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  function automatic vec_t mk(input logic start, input logic [63:0] frame, input logic rdy,
                              input logic vld, input logic [15:0] data, input logic last,
                              input logic row, input logic col, input logic irdy);
    vec_t v;
    v.start = start; v.frame = frame; v.rdy = rdy; v.vld = vld; v.data = data;
    v.last = last; v.row = row; v.col = col; v.irdy = irdy;
    return v;
  endfunction

  task automatic chk_beat(input string tag, input logic vld, input logic [15:0] data,
                          input logic last, input logic row, input logic col);
    chk({tag, ".valid"}, 32'(m_valid), 32'(vld));
    chk({tag, ".data"}, 32'(m_data), 32'(data));
    chk({tag, ".last"}, 32'(m_last), 32'(last));
    chk({tag, ".ch"}, 32'(m_ch), 32'd0);
    chk({tag, ".row"}, 32'(m_row), 32'(row));
    chk({tag, ".col"}, 32'(m_col), 32'(col));
  endtask

  task automatic capture(input logic [63:0] frame);
    @(negedge clk);
    result_in = frame;
    in_valid  = 1'b1;
    m_ready   = 1'b1;
  endtask

  initial begin
    // Basic drain, m_ready held high.
    tbl.push_back(mk(1, FrameA, 1, 1, 16'h3C00, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 1, 1, 16'hBC00, 0, 0, 1, 0));
    tbl.push_back(mk(0, '0, 1, 1, 16'h4000, 0, 1, 0, 0));
    tbl.push_back(mk(0, '0, 1, 1, 16'h0000, 1, 1, 1, 1));
    tbl.push_back(mk(0, '0, 1, 0, 16'h0000, 0, 0, 0, 1));
    // Backpressure: ready pattern 1,0,0,1,1,0,1.
    tbl.push_back(mk(1, FrameA, 1, 1, 16'h3C00, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 1, 16'hBC00, 0, 0, 1, 0));
    tbl.push_back(mk(0, '0, 0, 1, 16'hBC00, 0, 0, 1, 0));
    tbl.push_back(mk(0, '0, 1, 1, 16'hBC00, 0, 0, 1, 0));
    tbl.push_back(mk(0, '0, 1, 1, 16'h4000, 0, 1, 0, 0));
    tbl.push_back(mk(0, '0, 0, 1, 16'h0000, 1, 1, 1, 0));
    tbl.push_back(mk(0, '0, 1, 1, 16'h0000, 1, 1, 1, 1));
    tbl.push_back(mk(0, '0, 1, 0, 16'h0000, 0, 0, 0, 1));
    // Sign-bit frame: zeroed negatives only in the ReLU build.
    tbl.push_back(mk(1, FrameR, 1, 1, relu_ref(16'hBC00), 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, 1, 1, relu_ref(16'h3C00), 0, 0, 1, 0));
    tbl.push_back(mk(0, '0, 1, 1, relu_ref(16'h8000), 0, 1, 0, 0));
    tbl.push_back(mk(0, '0, 1, 1, relu_ref(16'h4000), 1, 1, 1, 1));
    tbl.push_back(mk(0, '0, 1, 0, 16'h0000, 0, 0, 0, 1));

    // Reset state.
    repeat (2) @(negedge clk);
    chk_beat("reset", 0, 16'h0000, 0, 0, 0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.overrun", 32'(overrun), 32'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].start) capture(tbl[i].frame);
      @(negedge clk);
      in_valid = 1'b0;
      m_ready  = tbl[i].rdy;
      #1;
      chk_beat($sformatf("vec%0d", i), tbl[i].vld, tbl[i].data, tbl[i].last, tbl[i].row,
               tbl[i].col);
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].irdy));
    end

    // Back-to-back: next frame offered on the last handshake.
    capture(FrameA);
    @(negedge clk); in_valid = 1'b0; #1 chk_beat("b2b0", 1, 16'h3C00, 0, 0, 0);
    @(negedge clk); #1 chk_beat("b2b1", 1, 16'hBC00, 0, 0, 1);
    @(negedge clk); #1 chk_beat("b2b2", 1, 16'h4000, 0, 1, 0);
    @(negedge clk);
    result_in = FrameB;
    in_valid  = 1'b1;
    #1 chk_beat("b2b3", 1, 16'h0000, 1, 1, 1);
    chk("b2b3.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0; #1 chk_beat("b2b4", 1, 16'h0001, 0, 0, 0);
    @(negedge clk); #1 chk_beat("b2b5", 1, 16'h0002, 0, 0, 1);
    @(negedge clk); #1 chk_beat("b2b6", 1, 16'h0003, 0, 1, 0);
    @(negedge clk); #1 chk_beat("b2b7", 1, 16'h0004, 1, 1, 1);
    @(negedge clk); #1 chk_beat("b2b8", 0, 16'h0000, 0, 0, 0);
    chk("b2b.overrun", 32'(overrun), 32'd0);

    // Overrun: a frame offered mid-stream is dropped and flagged.
    capture(FrameA);
    @(negedge clk); in_valid = 1'b0; #1 chk_beat("ovr0", 1, 16'h3C00, 0, 0, 0);
    @(negedge clk);
    result_in = FrameB;
    in_valid  = 1'b1;
    #1 chk_beat("ovr1", 1, 16'hBC00, 0, 0, 1);
    chk("ovr1.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); in_valid = 1'b0; #1 chk_beat("ovr2", 1, 16'h4000, 0, 1, 0);
    chk("ovr2.overrun", 32'(overrun), 32'd1);
    @(negedge clk); #1 chk_beat("ovr3", 1, 16'h0000, 1, 1, 1);
    @(negedge clk); #1 chk_beat("ovr4", 0, 16'h0000, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("ovr.sticky", 32'(overrun), 32'd1);

    // Reset mid-stream abandons the frame; the next frame starts at element 0.
    capture(FrameA);
    @(negedge clk); in_valid = 1'b0; #1 chk_beat("rst0", 1, 16'h3C00, 0, 0, 0);
    @(negedge clk); reset = 1'b0; #1 chk_beat("rst1", 0, 16'h0000, 0, 0, 0);
    chk("rst1.in_ready", 32'(in_ready), 32'd1);
    chk("rst1.overrun", 32'(overrun), 32'd0);
    @(negedge clk); reset = 1'b1;
    capture(FrameB);
    @(negedge clk); in_valid = 1'b0; #1 chk_beat("rst2", 1, 16'h0001, 0, 0, 0);
    @(negedge clk); #1 chk_beat("rst3", 1, 16'h0002, 0, 0, 1);
    @(negedge clk); #1 chk_beat("rst4", 1, 16'h0003, 0, 1, 0);
    @(negedge clk); #1 chk_beat("rst5", 1, 16'h0004, 1, 1, 1);
    @(negedge clk); #1 chk_beat("rst6", 0, 16'h0000, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
